// File: rtl/switch_buffered.sv
// switch_buffered: inter-core message switch with one DEPTH-entry FIFO per
// sender. Receivers name a source core; the head entry of that source's FIFO
// is delivered once it is addressed to the receiver. Requests are sticky
// until served.
module switch_buffered #(
  parameter int WIDTH          = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int CORE_SIZE      = 3,
  parameter int DEPTH          = 4,
  parameter int CORE_ADDR_SIZE = $clog2(CORE_SIZE),
  parameter int CNT_SIZE       = $clog2(DEPTH + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 send_ready    [CORE_SIZE-1:0],
  input  logic [CORE_ADDR_SIZE-1:0]            send_core_idx [CORE_SIZE-1:0],
  input  logic [WIDTH-1:0][DATA_WIDTH-1:0]     send_data     [CORE_SIZE-1:0],
  output logic                                 send_ok       [CORE_SIZE-1:0],
  output logic [CNT_SIZE-1:0]                  send_count    [CORE_SIZE-1:0],
  input  logic                                 recv_request  [CORE_SIZE-1:0],
  input  logic [CORE_ADDR_SIZE-1:0]            recv_core_idx [CORE_SIZE-1:0],
  output logic                                 recv_ready    [CORE_SIZE-1:0],
  output logic [WIDTH-1:0][DATA_WIDTH-1:0]     recv_data     [CORE_SIZE-1:0]
);

  typedef logic [WIDTH-1:0][DATA_WIDTH-1:0] payload_t;
  typedef logic [CORE_ADDR_SIZE-1:0]        core_t;

  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1       = CORE_ADDR_SIZE + 1;
  localparam int PAYLOAD_W = WIDTH * DATA_WIDTH;

  localparam logic [PTR_W-1:0]    LAST_PTR     = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]    PTR_ONE      = PTR_W'(1);
  localparam logic [CNT_SIZE-1:0] DEPTH_CNT    = CNT_SIZE'(DEPTH);
  localparam logic [CNT_SIZE-1:0] CNT_ONE      = CNT_SIZE'(1);
  localparam logic [AW1-1:0]      CORE_LIM     = AW1'(CORE_SIZE);
  localparam payload_t            PAYLOAD_ZERO = {PAYLOAD_W{1'b0}};

  // Circular pointer advance; wraps at DEPTH-1 so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : (p + PTR_ONE);
  endfunction

  // True when a core index names an existing port.
  function automatic logic in_range(input core_t idx);
    return ({1'b0, idx} < CORE_LIM);
  endfunction

  // FIFO storage and bookkeeping
  core_t               fifo_dest_r [CORE_SIZE-1:0][DEPTH-1:0];
  payload_t            fifo_data_r [CORE_SIZE-1:0][DEPTH-1:0];
  logic [PTR_W-1:0]    wr_ptr_r    [CORE_SIZE-1:0];
  logic [PTR_W-1:0]    rd_ptr_r    [CORE_SIZE-1:0];
  logic [CNT_SIZE-1:0] count_r     [CORE_SIZE-1:0];

  // Receive-side state
  logic                pend_r      [CORE_SIZE-1:0];
  core_t               pend_src_r  [CORE_SIZE-1:0];

  // Combinational helpers
  core_t               head_dest_s  [CORE_SIZE-1:0];
  payload_t            head_data_s  [CORE_SIZE-1:0];
  logic                head_valid_s [CORE_SIZE-1:0];
  logic                eff_valid_s  [CORE_SIZE-1:0];
  core_t               eff_src_s    [CORE_SIZE-1:0];
  logic                hit_s        [CORE_SIZE-1:0][CORE_SIZE-1:0];
  logic                match_s      [CORE_SIZE-1:0];
  payload_t            sel_data_s   [CORE_SIZE-1:0];
  logic                pop_s        [CORE_SIZE-1:0];

  // Head-of-FIFO view, acceptance decision and occupancy output per sender.
  always_comb begin
    for (int s = 0; s < CORE_SIZE; s++) begin
      head_dest_s[s]  = fifo_dest_r[s][rd_ptr_r[s]];
      head_data_s[s]  = fifo_data_r[s][rd_ptr_r[s]];
      head_valid_s[s] = (count_r[s] != {CNT_SIZE{1'b0}});
      send_ok[s]      = send_ready[s] && (count_r[s] < DEPTH_CNT) &&
                        in_range(send_core_idx[s]) && reset;
      send_count[s]   = count_r[s];
    end
  end

  // Effective source per receiver, head/destination match and resulting pops.
  always_comb begin
    for (int r = 0; r < CORE_SIZE; r++) begin
      eff_valid_s[r] = 1'b0;
      eff_src_s[r]   = {CORE_ADDR_SIZE{1'b0}};
      match_s[r]     = 1'b0;
      sel_data_s[r]  = PAYLOAD_ZERO;
      if (pend_r[r]) begin
        eff_valid_s[r] = 1'b1;
        eff_src_s[r]   = pend_src_r[r];
      end else if (recv_request[r] && in_range(recv_core_idx[r])) begin
        eff_valid_s[r] = 1'b1;
        eff_src_s[r]   = recv_core_idx[r];
      end else begin
        eff_valid_s[r] = 1'b0;
        eff_src_s[r]   = {CORE_ADDR_SIZE{1'b0}};
      end
      for (int s = 0; s < CORE_SIZE; s++) begin
        hit_s[r][s]   = eff_valid_s[r] && (eff_src_s[r] == core_t'(s)) &&
                        head_valid_s[s] && (head_dest_s[s] == core_t'(r));
        match_s[r]    = match_s[r] | hit_s[r][s];
        sel_data_s[r] = sel_data_s[r] | (head_data_s[s] & {PAYLOAD_W{hit_s[r][s]}});
      end
    end
    // A head has a single destination, so at most one receiver hits each FIFO.
    for (int s = 0; s < CORE_SIZE; s++) begin
      pop_s[s] = 1'b0;
      for (int r = 0; r < CORE_SIZE; r++) begin
        pop_s[s] = pop_s[s] | hit_s[r][s];
      end
    end
  end

  // FIFO payload storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CORE_SIZE; c++) begin
      if (send_ok[c]) begin
        fifo_dest_r[c][wr_ptr_r[c]] <= send_core_idx[c];
        fifo_data_r[c][wr_ptr_r[c]] <= send_data[c];
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CORE_SIZE; c++) begin
        wr_ptr_r[c] <= {PTR_W{1'b0}};
        rd_ptr_r[c] <= {PTR_W{1'b0}};
        count_r[c]  <= {CNT_SIZE{1'b0}};
      end
    end else begin
      for (int c = 0; c < CORE_SIZE; c++) begin
        if (send_ok[c]) begin
          wr_ptr_r[c] <= next_ptr(wr_ptr_r[c]);
        end
        if (pop_s[c]) begin
          rd_ptr_r[c] <= next_ptr(rd_ptr_r[c]);
        end
        case ({send_ok[c], pop_s[c]})
          2'b10:   count_r[c] <= count_r[c] + CNT_ONE;
          2'b01:   count_r[c] <= count_r[c] - CNT_ONE;
          default: count_r[c] <= count_r[c];
        endcase
      end
    end
  end

  // Sticky request tracking plus registered delivery pulse and payload.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < CORE_SIZE; r++) begin
        pend_r[r]     <= 1'b0;
        pend_src_r[r] <= {CORE_ADDR_SIZE{1'b0}};
        recv_ready[r] <= 1'b0;
        recv_data[r]  <= PAYLOAD_ZERO;
      end
    end else begin
      for (int r = 0; r < CORE_SIZE; r++) begin
        recv_ready[r] <= match_s[r];
        if (match_s[r]) begin
          recv_data[r] <= sel_data_s[r];
          pend_r[r]    <= 1'b0;
        end else if (eff_valid_s[r]) begin
          pend_r[r]     <= 1'b1;
          pend_src_r[r] <= eff_src_s[r];
        end else begin
          pend_r[r] <= pend_r[r];
        end
      end
    end
  end

endmodule
